// File: rtl/cpu_pkg.sv
// Shared definitions for the bus-based CPU control path: opcodes, sequencer
// states, instruction classes and the control word driven onto the datapath.
package cpu_pkg;

  localparam int unsigned OPC_W = 5;
  localparam logic [OPC_W-1:0] ADD_OP = 5'b00011;

  localparam logic [OPC_W-1:0] OPC_LD   = 5'b00000;
  localparam logic [OPC_W-1:0] OPC_LDI  = 5'b00001;
  localparam logic [OPC_W-1:0] OPC_ST   = 5'b00010;
  localparam logic [OPC_W-1:0] OPC_ADD  = 5'b00011;
  localparam logic [OPC_W-1:0] OPC_SUB  = 5'b00100;
  localparam logic [OPC_W-1:0] OPC_SHR  = 5'b00101;
  localparam logic [OPC_W-1:0] OPC_SHRA = 5'b00110;
  localparam logic [OPC_W-1:0] OPC_SHL  = 5'b00111;
  localparam logic [OPC_W-1:0] OPC_ROR  = 5'b01000;
  localparam logic [OPC_W-1:0] OPC_ROL  = 5'b01001;
  localparam logic [OPC_W-1:0] OPC_AND  = 5'b01010;
  localparam logic [OPC_W-1:0] OPC_OR   = 5'b01011;
  localparam logic [OPC_W-1:0] OPC_ADDI = 5'b01100;
  localparam logic [OPC_W-1:0] OPC_ANDI = 5'b01101;
  localparam logic [OPC_W-1:0] OPC_ORI  = 5'b01110;
  localparam logic [OPC_W-1:0] OPC_DIV  = 5'b01111;
  localparam logic [OPC_W-1:0] OPC_MUL  = 5'b10000;
  localparam logic [OPC_W-1:0] OPC_NEG  = 5'b10001;
  localparam logic [OPC_W-1:0] OPC_NOT  = 5'b10010;
  localparam logic [OPC_W-1:0] OPC_BR   = 5'b10011;
  localparam logic [OPC_W-1:0] OPC_JR   = 5'b10100;
  localparam logic [OPC_W-1:0] OPC_JAL  = 5'b10101;
  localparam logic [OPC_W-1:0] OPC_IN   = 5'b10110;
  localparam logic [OPC_W-1:0] OPC_OUT  = 5'b10111;
  localparam logic [OPC_W-1:0] OPC_MFLO = 5'b11000;
  localparam logic [OPC_W-1:0] OPC_MFHI = 5'b11001;
  localparam logic [OPC_W-1:0] OPC_NOP  = 5'b11010;
  localparam logic [OPC_W-1:0] OPC_HALT = 5'b11011;

  typedef enum logic [3:0] {
    RESET, T0, T1, T2, T3, T4, T5, T6, T7, HALT
  } state_t;

  typedef enum logic [3:0] {
    CLS_ALU, CLS_IMM, CLS_LD, CLS_LDI, CLS_ST, CLS_MULDIV, CLS_UNARY, CLS_BR,
    CLS_JR, CLS_JAL, CLS_IN, CLS_OUT, CLS_MFLO, CLS_MFHI, CLS_NOP, CLS_HALT
  } op_class_t;

  typedef struct packed {
    logic             run;
    logic             gra;
    logic             grb;
    logic             grc;
    logic             rin;
    logic             rout;
    logic             ba_out;
    logic             con_in;
    logic             pc_out;
    logic             mdr_out;
    logic             zhi_out;
    logic             zlo_out;
    logic             hi_out;
    logic             lo_out;
    logic             inport_out;
    logic             c_out;
    logic             pc_in;
    logic             ir_in;
    logic             mar_in;
    logic             mdr_in;
    logic             y_in;
    logic             zhigh_in;
    logic             zlow_in;
    logic             hi_in;
    logic             lo_in;
    logic             outport_in;
    logic             inc_pc;
    logic             read;
    logic             write;
    logic [OPC_W-1:0] operation;
  } ctrl_word_t;

  // Groups opcodes that share an execute sequence; undefined opcodes act as nop.
  function automatic op_class_t op_class(input logic [OPC_W-1:0] opc);
    case (opc)
      OPC_ADD, OPC_SUB, OPC_SHR, OPC_SHRA, OPC_SHL,
      OPC_ROR, OPC_ROL, OPC_AND, OPC_OR:  op_class = CLS_ALU;
      OPC_ADDI, OPC_ANDI, OPC_ORI:        op_class = CLS_IMM;
      OPC_LD:                             op_class = CLS_LD;
      OPC_LDI:                            op_class = CLS_LDI;
      OPC_ST:                             op_class = CLS_ST;
      OPC_DIV, OPC_MUL:                   op_class = CLS_MULDIV;
      OPC_NEG, OPC_NOT:                   op_class = CLS_UNARY;
      OPC_BR:                             op_class = CLS_BR;
      OPC_JR:                             op_class = CLS_JR;
      OPC_JAL:                            op_class = CLS_JAL;
      OPC_IN:                             op_class = CLS_IN;
      OPC_OUT:                            op_class = CLS_OUT;
      OPC_MFLO:                           op_class = CLS_MFLO;
      OPC_MFHI:                           op_class = CLS_MFHI;
      OPC_HALT:                           op_class = CLS_HALT;
      default:                            op_class = CLS_NOP;
    endcase
  endfunction

  // Number of execute steps (T3 onward) for each class.
  function automatic logic [2:0] exec_len(input op_class_t cls);
    case (cls)
      CLS_ALU, CLS_IMM, CLS_LDI:                      exec_len = 3'd3;
      CLS_LD, CLS_ST:                                 exec_len = 3'd5;
      CLS_MULDIV, CLS_BR:                             exec_len = 3'd4;
      CLS_UNARY, CLS_JAL:                             exec_len = 3'd2;
      CLS_JR, CLS_IN, CLS_OUT, CLS_MFLO, CLS_MFHI:    exec_len = 3'd1;
      default:                                        exec_len = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/control_step_decode.sv
// Combinational decode of (step, opcode, branch condition) into the datapath
// control word.
module control_step_decode
  import cpu_pkg::*;
(
  input  state_t           state,
  input  logic [OPC_W-1:0] opcode,
  input  logic             con_out,
  output ctrl_word_t       cw
);

  op_class_t cls;
  assign cls = op_class(opcode);

  always_comb begin
    cw = '0;
    cw.run = (state != RESET) && (state != HALT);
    case (state)
      T0: begin cw.pc_out = 1'b1; cw.mar_in = 1'b1; cw.inc_pc = 1'b1; cw.zlow_in = 1'b1; end
      T1: begin cw.zlo_out = 1'b1; cw.pc_in = 1'b1; cw.read = 1'b1; cw.mdr_in = 1'b1; end
      T2: begin cw.mdr_out = 1'b1; cw.ir_in = 1'b1; end
      T3: begin
        case (cls)
          CLS_ALU, CLS_IMM: begin cw.grb = 1'b1; cw.rout = 1'b1; cw.y_in = 1'b1; end
          CLS_LD, CLS_LDI, CLS_ST: begin cw.grb = 1'b1; cw.ba_out = 1'b1; cw.y_in = 1'b1; end
          CLS_MULDIV: begin cw.gra = 1'b1; cw.rout = 1'b1; cw.y_in = 1'b1; end
          CLS_UNARY: begin
            cw.grb = 1'b1; cw.rout = 1'b1; cw.operation = opcode; cw.zlow_in = 1'b1;
          end
          CLS_BR:   begin cw.gra = 1'b1; cw.rout = 1'b1; cw.con_in = 1'b1; end
          CLS_JR:   begin cw.gra = 1'b1; cw.rout = 1'b1; cw.pc_in = 1'b1; end
          CLS_JAL:  begin cw.pc_out = 1'b1; cw.grb = 1'b1; cw.rin = 1'b1; end
          CLS_IN:   begin cw.inport_out = 1'b1; cw.gra = 1'b1; cw.rin = 1'b1; end
          CLS_OUT:  begin cw.gra = 1'b1; cw.rout = 1'b1; cw.outport_in = 1'b1; end
          CLS_MFLO: begin cw.lo_out = 1'b1; cw.gra = 1'b1; cw.rin = 1'b1; end
          CLS_MFHI: begin cw.hi_out = 1'b1; cw.gra = 1'b1; cw.rin = 1'b1; end
          default: ;
        endcase
      end
      T4: begin
        case (cls)
          CLS_ALU: begin
            cw.grc = 1'b1; cw.rout = 1'b1; cw.operation = opcode; cw.zlow_in = 1'b1;
          end
          CLS_IMM: begin cw.c_out = 1'b1; cw.operation = opcode; cw.zlow_in = 1'b1; end
          CLS_LD, CLS_LDI, CLS_ST: begin
            cw.c_out = 1'b1; cw.operation = ADD_OP; cw.zlow_in = 1'b1;
          end
          CLS_MULDIV: begin
            cw.grb = 1'b1; cw.rout = 1'b1; cw.operation = opcode;
            cw.zhigh_in = 1'b1; cw.zlow_in = 1'b1;
          end
          CLS_UNARY: begin cw.zlo_out = 1'b1; cw.gra = 1'b1; cw.rin = 1'b1; end
          CLS_BR:    begin cw.pc_out = 1'b1; cw.y_in = 1'b1; end
          CLS_JAL:   begin cw.gra = 1'b1; cw.rout = 1'b1; cw.pc_in = 1'b1; end
          default: ;
        endcase
      end
      T5: begin
        case (cls)
          CLS_ALU, CLS_IMM, CLS_LDI: begin cw.zlo_out = 1'b1; cw.gra = 1'b1; cw.rin = 1'b1; end
          CLS_LD, CLS_ST: begin cw.zlo_out = 1'b1; cw.mar_in = 1'b1; end
          CLS_MULDIV:     begin cw.zlo_out = 1'b1; cw.lo_in = 1'b1; end
          CLS_BR: begin cw.c_out = 1'b1; cw.operation = ADD_OP; cw.zlow_in = 1'b1; end
          default: ;
        endcase
      end
      T6: begin
        case (cls)
          CLS_LD:     begin cw.read = 1'b1; cw.mdr_in = 1'b1; end
          CLS_ST:     begin cw.gra = 1'b1; cw.rout = 1'b1; cw.mdr_in = 1'b1; end
          CLS_MULDIV: begin cw.zhi_out = 1'b1; cw.hi_in = 1'b1; end
          // Branch target is written only when the condition flop is set.
          CLS_BR:     begin cw.zlo_out = 1'b1; cw.pc_in = con_out; end
          default: ;
        endcase
      end
      T7: begin
        case (cls)
          CLS_LD: begin cw.mdr_out = 1'b1; cw.gra = 1'b1; cw.rin = 1'b1; end
          CLS_ST: cw.write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired Moore sequencer: step register and next-step logic; the control
// word for each step comes from control_step_decode.
module control_unit
  import cpu_pkg::*;
(
  input  logic             clock,
  input  logic             clear,
  input  logic [31:0]      IR,
  input  logic             CON_out,
  input  logic             stop,
  output logic             run,
  output logic             Gra,
  output logic             Grb,
  output logic             Grc,
  output logic             Rin,
  output logic             Rout,
  output logic             BAout,
  output logic             CON_in,
  output logic             PCout,
  output logic             MDRout,
  output logic             ZHIout,
  output logic             ZLOout,
  output logic             HIout,
  output logic             LOout,
  output logic             Inportout,
  output logic             Cout,
  output logic             PCin,
  output logic             IRin,
  output logic             MARin,
  output logic             MDRin,
  output logic             Yin,
  output logic             Zhighin,
  output logic             Zlowin,
  output logic             HIin,
  output logic             LOin,
  output logic             OutPortin,
  output logic             IncPC,
  output logic             read,
  output logic             write,
  output logic [OPC_W-1:0] operation
);

  state_t           state, state_next;
  logic [OPC_W-1:0] opcode;
  logic [2:0]       len;
  logic             last;
  logic             unused_ir;
  ctrl_word_t       cw;

  assign opcode    = IR[31:27];
  assign unused_ir = ^IR[26:0];
  assign len       = exec_len(op_class(opcode));

  always_ff @(posedge clock or posedge clear) begin
    if (clear) state <= RESET;
    else       state <= state_next;
  end

  // Advance one step; on an instruction's final step go to T0 or HALT.
  always_comb begin
    state_next = state;
    last       = 1'b0;
    case (state)
      RESET: state_next = T0;
      T0:    state_next = T1;
      T1:    state_next = T2;
      T2: begin
        state_next = T3;
        last       = (len == 3'd0);
        if (op_class(opcode) == CLS_HALT) begin
          state_next = HALT;
          last       = 1'b0;
        end
      end
      T3: begin state_next = T4; last = (len <= 3'd1); end
      T4: begin state_next = T5; last = (len <= 3'd2); end
      T5: begin state_next = T6; last = (len <= 3'd3); end
      T6: begin state_next = T7; last = (len <= 3'd4); end
      T7:    last = 1'b1;
      HALT:  state_next = HALT;
      default: state_next = RESET;
    endcase
    if (last) state_next = stop ? HALT : T0;
  end

  control_step_decode u_decode (
    .state   (state),
    .opcode  (opcode),
    .con_out (CON_out),
    .cw      (cw)
  );

  assign run       = cw.run;
  assign Gra       = cw.gra;
  assign Grb       = cw.grb;
  assign Grc       = cw.grc;
  assign Rin       = cw.rin;
  assign Rout      = cw.rout;
  assign BAout     = cw.ba_out;
  assign CON_in    = cw.con_in;
  assign PCout     = cw.pc_out;
  assign MDRout    = cw.mdr_out;
  assign ZHIout    = cw.zhi_out;
  assign ZLOout    = cw.zlo_out;
  assign HIout     = cw.hi_out;
  assign LOout     = cw.lo_out;
  assign Inportout = cw.inport_out;
  assign Cout      = cw.c_out;
  assign PCin      = cw.pc_in;
  assign IRin      = cw.ir_in;
  assign MARin     = cw.mar_in;
  assign MDRin     = cw.mdr_in;
  assign Yin       = cw.y_in;
  assign Zhighin   = cw.zhigh_in;
  assign Zlowin    = cw.zlow_in;
  assign HIin      = cw.hi_in;
  assign LOin      = cw.lo_in;
  assign OutPortin = cw.outport_in;
  assign IncPC     = cw.inc_pc;
  assign read      = cw.read;
  assign write     = cw.write;
  assign operation = cw.operation;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: each instruction is expanded into its
// expected list of per-step control words and compared cycle by cycle.
module tb_control_unit;

  logic        clock = 1'b0;
  logic        clear, stop, CON_out;
  logic [31:0] IR;
  logic run, Gra, Grb, Grc, Rin, Rout, BAout, CON_in, PCout, MDRout, ZHIout, ZLOout;
  logic HIout, LOout, Inportout, Cout, PCin, IRin, MARin, MDRin, Yin, Zhighin, Zlowin;
  logic HIin, LOin, OutPortin, IncPC, read, write;
  logic [4:0] operation;

  always #5 clock = ~clock;

  control_unit dut (
    .clock(clock), .clear(clear), .IR(IR), .CON_out(CON_out), .stop(stop), .run(run),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout), .CON_in(CON_in),
    .PCout(PCout), .MDRout(MDRout), .ZHIout(ZHIout), .ZLOout(ZLOout), .HIout(HIout),
    .LOout(LOout), .Inportout(Inportout), .Cout(Cout), .PCin(PCin), .IRin(IRin),
    .MARin(MARin), .MDRin(MDRin), .Yin(Yin), .Zhighin(Zhighin), .Zlowin(Zlowin),
    .HIin(HIin), .LOin(LOin), .OutPortin(OutPortin), .IncPC(IncPC), .read(read),
    .write(write), .operation(operation)
  );

  // Observed word: {run, operation, strobes}; strobe bit positions below.
  logic [33:0] obs;
  assign obs = {run, operation, write, read, IncPC, OutPortin, LOin, HIin, Zlowin, Zhighin,
                Yin, MDRin, MARin, IRin, PCin, Cout, Inportout, LOout, HIout, ZLOout, ZHIout,
                MDRout, PCout, CON_in, BAout, Rout, Rin, Grc, Grb, Gra};

  localparam logic [27:0] GRA = 28'h0000001, GRB = 28'h0000002, GRC = 28'h0000004;
  localparam logic [27:0] RIN = 28'h0000008, ROUT = 28'h0000010, BAOUT = 28'h0000020;
  localparam logic [27:0] CONIN = 28'h0000040, PCOUT = 28'h0000080, MDROUT = 28'h0000100;
  localparam logic [27:0] ZHIOUT = 28'h0000200, ZLOOUT = 28'h0000400, HIOUT = 28'h0000800;
  localparam logic [27:0] LOOUT = 28'h0001000, INPOUT = 28'h0002000, COUT = 28'h0004000;
  localparam logic [27:0] PCIN = 28'h0008000, IRIN = 28'h0010000, MARIN = 28'h0020000;
  localparam logic [27:0] MDRIN = 28'h0040000, YIN = 28'h0080000, ZHIGHIN = 28'h0100000;
  localparam logic [27:0] ZLOWIN = 28'h0200000, HIIN = 28'h0400000, LOIN = 28'h0800000;
  localparam logic [27:0] OUTPIN = 28'h1000000, INCPC = 28'h2000000, READ = 28'h4000000;
  localparam logic [27:0] WRITE = 28'h8000000;
  localparam logic [4:0]  ADDOP = 5'b00011;

  int checks = 0;
  int failures = 0;
  logic [33:0] exp_q[$];

  function automatic logic [33:0] w(input logic [4:0] op, input logic [27:0] s);
    return {1'b1, op, s};
  endfunction

  // Reference: the instruction's full step list straight from the opcode table.
  task automatic plan(input logic [4:0] opc, input logic con);
    int o;
    o = int'(opc);
    exp_q.delete();
    exp_q.push_back(w(5'd0, PCOUT | MARIN | INCPC | ZLOWIN));
    exp_q.push_back(w(5'd0, ZLOOUT | PCIN | READ | MDRIN));
    exp_q.push_back(w(5'd0, MDROUT | IRIN));
    if (o >= 3 && o <= 14) begin
      exp_q.push_back(w(5'd0, GRB | ROUT | YIN));
      exp_q.push_back(w(opc, ((o <= 11) ? (GRC | ROUT) : COUT) | ZLOWIN));
      exp_q.push_back(w(5'd0, ZLOOUT | GRA | RIN));
    end else if (o <= 2) begin
      exp_q.push_back(w(5'd0, GRB | BAOUT | YIN));
      exp_q.push_back(w(ADDOP, COUT | ZLOWIN));
      if (o == 1) exp_q.push_back(w(5'd0, ZLOOUT | GRA | RIN));
      else begin
        exp_q.push_back(w(5'd0, ZLOOUT | MARIN));
        if (o == 0) begin
          exp_q.push_back(w(5'd0, READ | MDRIN));
          exp_q.push_back(w(5'd0, MDROUT | GRA | RIN));
        end else begin
          exp_q.push_back(w(5'd0, GRA | ROUT | MDRIN));
          exp_q.push_back(w(5'd0, WRITE));
        end
      end
    end else if (o == 15 || o == 16) begin
      exp_q.push_back(w(5'd0, GRA | ROUT | YIN));
      exp_q.push_back(w(opc, GRB | ROUT | ZHIGHIN | ZLOWIN));
      exp_q.push_back(w(5'd0, ZLOOUT | LOIN));
      exp_q.push_back(w(5'd0, ZHIOUT | HIIN));
    end else if (o == 17 || o == 18) begin
      exp_q.push_back(w(opc, GRB | ROUT | ZLOWIN));
      exp_q.push_back(w(5'd0, ZLOOUT | GRA | RIN));
    end else if (o == 19) begin
      exp_q.push_back(w(5'd0, GRA | ROUT | CONIN));
      exp_q.push_back(w(5'd0, PCOUT | YIN));
      exp_q.push_back(w(ADDOP, COUT | ZLOWIN));
      exp_q.push_back(w(5'd0, ZLOOUT | (con ? PCIN : 28'd0)));
    end else if (o == 20) exp_q.push_back(w(5'd0, GRA | ROUT | PCIN));
    else if (o == 21) begin
      exp_q.push_back(w(5'd0, PCOUT | GRB | RIN));
      exp_q.push_back(w(5'd0, GRA | ROUT | PCIN));
    end
    else if (o == 22) exp_q.push_back(w(5'd0, INPOUT | GRA | RIN));
    else if (o == 23) exp_q.push_back(w(5'd0, GRA | ROUT | OUTPIN));
    else if (o == 24) exp_q.push_back(w(5'd0, LOOUT | GRA | RIN));
    else if (o == 25) exp_q.push_back(w(5'd0, HIOUT | GRA | RIN));
  endtask

  task automatic check(input string tag, input logic [33:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
    checks++;
    assert (!(read && write)) else begin
      failures++;
      $error("FAIL %s read_write observed=%b%b expected=not both", tag, read, write);
    end
  endtask

  // Entered at posedge+1 of T0; returns at posedge+1 of the following step.
  task automatic run_instr(input string name, input logic [31:0] ir, input logic con,
                           input logic stp);
    int n;
    IR = ir;
    CON_out = con;
    plan(ir[31:27], con);
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      #4;
      check($sformatf("%s.step%0d", name, i), exp_q[i]);
      stop = (i == n - 1) ? stp : 1'($urandom_range(0, 1));
      @(posedge clock); #1;
      stop = 1'b0;
    end
  endtask

  task automatic check_halt(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      #4;
      check($sformatf("%s.halt%0d", name, i), 34'd0);
      @(posedge clock); #1;
    end
  endtask

  task automatic do_reset(input string name);
    clear = 1'b1;
    #1;
    check({name, ".clear"}, 34'd0);
    @(posedge clock); #1;
    clear = 1'b0;
    @(posedge clock); #1;
  endtask

  initial begin
    logic [4:0] opc;
    logic       stp;
    clear = 1'b1; stop = 1'b0; CON_out = 1'b0; IR = 32'd0;
    repeat (2) @(posedge clock);
    #1;
    check("reset_hold", 34'd0);
    clear = 1'b0;
    #2;
    check("reset_released", 34'd0);
    @(posedge clock); #1;

    run_instr("add", 32'h1A920000, 1'b0, 1'b0);
    run_instr("ld", 32'h00000000, 1'b0, 1'b0);
    run_instr("br_nt", {5'b10011, 27'h0123456}, 1'b0, 1'b0);
    run_instr("br_t", {5'b10011, 27'h0654321}, 1'b1, 1'b0);
    run_instr("mflo", {5'b11000, 27'd0}, 1'b0, 1'b0);
    run_instr("mfhi", {5'b11001, 27'd0}, 1'b0, 1'b0);
    run_instr("nop", {5'b11010, 27'd0}, 1'b0, 1'b0);

    // Clear in the middle of T4 of a mul.
    IR = {5'b10000, 27'h0ABCDEF};
    plan(5'b10000, 1'b0);
    for (int i = 0; i < 4; i++) begin
      #4; check($sformatf("mul_pre.step%0d", i), exp_q[i]);
      @(posedge clock); #1;
    end
    #1; check("mul_t4", exp_q[4]);
    clear = 1'b1;
    #1; check("mul_clear_same_cycle", 34'd0);
    @(posedge clock); #1;
    clear = 1'b0;
    #1; check("mul_after_clear", 34'd0);
    @(posedge clock); #1;

    run_instr("st", {5'b00010, 27'h0000011}, 1'b0, 1'b0);
    run_instr("halt", {5'b11011, 27'd0}, 1'b0, 1'b0);
    check_halt("halt", 20);
    do_reset("halt");
    run_instr("add_stop", 32'h1A920000, 1'b0, 1'b1);
    check_halt("add_stop", 5);
    do_reset("add_stop");

    for (int k = 0; k < 80; k++) begin
      opc = 5'($urandom_range(0, 31));
      stp = ($urandom_range(0, 9) == 0);
      run_instr($sformatf("rnd%0d_op%0d", k, opc), {opc, 27'($urandom)},
                1'($urandom_range(0, 1)), stp);
      if (stp || opc == 5'b11011) begin
        check_halt($sformatf("rnd%0d", k), 3);
        do_reset($sformatf("rnd%0d", k));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
